// File: rtl/secuenciador_motores.sv
// secuenciador_motores: runs pump motors R, G, B one at a time for their latched
// tick counts, with a fixed idle gap between active channels.
module secuenciador_motores #(
    parameter int unsigned GAP_TICKS  = 2,
    parameter int unsigned MAX_CICLOS = 9,
    parameter int unsigned W          = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] ciclos_R,
    input  logic [W-1:0] ciclos_G,
    input  logic [W-1:0] ciclos_B,
    output logic [2:0]   motores,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [1:0]   canal,
    output logic [W-1:0] restantes
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;

    state_t       r_state,     w_state_nxt;
    logic [W-1:0] r_cnt_r,     w_cnt_r_nxt;
    logic [W-1:0] r_cnt_g,     w_cnt_g_nxt;
    logic [W-1:0] r_cnt_b,     w_cnt_b_nxt;
    logic [2:0]   r_motores,   w_motores_nxt;
    logic         r_busy,      w_busy_nxt;
    logic         r_done,      w_done_nxt;
    logic         r_error,     w_error_nxt;
    logic [1:0]   r_canal,     w_canal_nxt;
    logic [W-1:0] r_restantes, w_restantes_nxt;

    logic         w_over;
    logic [1:0]   w_first;
    logic [1:0]   w_next;
    logic [W-1:0] w_cnt_first;
    logic [W-1:0] w_cnt_canal;

    // Motor enable for a channel number (1=R, 2=G, 3=B)
    function automatic logic [2:0] mask_of(input logic [1:0] ch);
        case (ch)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Latched count for a channel number
    function automatic logic [W-1:0] count_of(input logic [1:0] ch, input logic [W-1:0] cr,
                                              input logic [W-1:0] cg, input logic [W-1:0] cb);
        case (ch)
            2'd1:    return cr;
            2'd2:    return cg;
            2'd3:    return cb;
            default: return '0;
        endcase
    endfunction

    // Channel selection: range check, first active channel, next active channel after canal
    always_comb begin
        w_over  = (r_cnt_r > W'(MAX_CICLOS)) || (r_cnt_g > W'(MAX_CICLOS)) ||
                  (r_cnt_b > W'(MAX_CICLOS));
        w_first = (r_cnt_r != '0) ? 2'd1 :
                  (r_cnt_g != '0) ? 2'd2 :
                  (r_cnt_b != '0) ? 2'd3 : 2'd0;
        case (r_canal)
            2'd1:    w_next = (r_cnt_g != '0) ? 2'd2 : ((r_cnt_b != '0) ? 2'd3 : 2'd0);
            2'd2:    w_next = (r_cnt_b != '0) ? 2'd3 : 2'd0;
            default: w_next = 2'd0;
        endcase
        w_cnt_first = count_of(w_first, r_cnt_r, r_cnt_g, r_cnt_b);
        w_cnt_canal = count_of(r_canal, r_cnt_r, r_cnt_g, r_cnt_b);
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_r_nxt     = r_cnt_r;
        w_cnt_g_nxt     = r_cnt_g;
        w_cnt_b_nxt     = r_cnt_b;
        w_motores_nxt   = r_motores;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_error_nxt     = r_error;
        w_canal_nxt     = r_canal;
        w_restantes_nxt = r_restantes;

        if (abort) begin
            w_state_nxt     = S_IDLE;
            w_motores_nxt   = 3'b000;
            w_busy_nxt      = 1'b0;
            w_canal_nxt     = 2'd0;
            w_restantes_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_cnt_r_nxt = ciclos_R;
                        w_cnt_g_nxt = ciclos_G;
                        w_cnt_b_nxt = ciclos_B;
                        w_error_nxt = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_over) begin
                        w_error_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else if (w_first != 2'd0) begin
                        w_canal_nxt     = w_first;
                        w_restantes_nxt = w_cnt_first;
                        w_motores_nxt   = mask_of(w_first);
                        w_state_nxt     = S_RUN;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        if (r_restantes == W'(1)) begin
                            w_motores_nxt = 3'b000;
                            if (w_next != 2'd0) begin
                                w_canal_nxt     = w_next;
                                w_restantes_nxt = W'(GAP_TICKS);
                                w_state_nxt     = S_GAP;
                            end else begin
                                w_canal_nxt     = 2'd0;
                                w_restantes_nxt = '0;
                                w_busy_nxt      = 1'b0;
                                w_done_nxt      = 1'b1;
                                w_state_nxt     = S_DONE;
                            end
                        end else begin
                            w_restantes_nxt = r_restantes - W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (r_restantes == W'(1)) begin
                            w_restantes_nxt = w_cnt_canal;
                            w_motores_nxt   = mask_of(r_canal);
                            w_state_nxt     = S_RUN;
                        end else begin
                            w_restantes_nxt = r_restantes - W'(1);
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt_r     <= '0;
            r_cnt_g     <= '0;
            r_cnt_b     <= '0;
            r_motores   <= 3'b000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_canal     <= 2'd0;
            r_restantes <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt_r     <= w_cnt_r_nxt;
            r_cnt_g     <= w_cnt_g_nxt;
            r_cnt_b     <= w_cnt_b_nxt;
            r_motores   <= w_motores_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_canal     <= w_canal_nxt;
            r_restantes <= w_restantes_nxt;
        end
    end

    // restantes is never decremented from zero
    always_ff @(posedge clk) begin
        if (!reset && !abort && tick && (r_state == S_RUN || r_state == S_GAP)) begin
            assert (r_restantes != '0);
        end
    end

    assign motores   = r_motores;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign canal     = r_canal;
    assign restantes = r_restantes;

endmodule

// File: tb/tb_secuenciador_motores.sv
// Bench for secuenciador_motores against a phase-list reference model.
module tb_secuenciador_motores;

    localparam int W    = 5;
    localparam int GAP  = 2;
    localparam int MAXC = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tick = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] cR = '0;
    logic [W-1:0] cG = '0;
    logic [W-1:0] cB = '0;
    logic [2:0]   motores;
    logic         busy;
    logic         done;
    logic         error;
    logic [1:0]   canal;
    logic [W-1:0] restantes;
    logic [12:0]  vec;

    int checks = 0;
    int errors = 0;

    secuenciador_motores #(.GAP_TICKS(GAP), .MAX_CICLOS(MAXC), .W(W)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
        .ciclos_R(cR), .ciclos_G(cG), .ciclos_B(cB),
        .motores(motores), .busy(busy), .done(done), .error(error),
        .canal(canal), .restantes(restantes)
    );

    always #5 clk = ~clk;

    assign vec = {motores, busy, done, error, canal, restantes};

    // Reference model: a dispense cycle is a list of phases (motor on / gap), each lasting N ticks.
    typedef struct {
        logic [2:0] mask;
        logic [1:0] chan;
        int         len;
    } phase_t;

    phase_t     m_q[$];
    int         m_lat[3];
    bit         m_load = 0;
    bit         m_run  = 0;
    bit         m_done = 0;
    bit         m_err  = 0;
    logic [2:0] m_mot  = 3'b000;
    logic [1:0] m_canal = 2'd0;
    int         m_rem  = 0;

    function automatic logic [12:0] exp_vec();
        return {m_mot, (m_load || m_run), m_done, m_err, m_canal, W'(m_rem)};
    endfunction

    task automatic front();
        m_mot   = m_q[0].mask;
        m_canal = m_q[0].chan;
        m_rem   = m_q[0].len;
    endtask

    task automatic model_clear();
        m_load = 0; m_run = 0; m_q.delete();
        m_mot = 3'b000; m_canal = 2'd0; m_rem = 0;
    endtask

    task automatic model_edge(input bit t, input bit s, input bit a, input bit r);
        bit was_done;
        was_done = m_done;
        m_done   = 0;
        if (r) begin
            model_clear();
            m_err = 0;
        end else if (a) begin
            model_clear();
        end else if (m_load) begin
            m_load = 0;
            if (m_lat[0] > MAXC || m_lat[1] > MAXC || m_lat[2] > MAXC) begin
                m_err = 1;
            end else begin
                for (int ch = 0; ch < 3; ch++) begin
                    if (m_lat[ch] != 0) begin
                        if (m_q.size() != 0) m_q.push_back(phase_t'{3'b000, 2'(ch + 1), GAP});
                        m_q.push_back(phase_t'{3'(4 >> ch), 2'(ch + 1), m_lat[ch]});
                    end
                end
                if (m_q.size() == 0) m_done = 1;
                else begin
                    m_run = 1;
                    front();
                end
            end
        end else if (m_run) begin
            if (t) begin
                m_rem--;
                if (m_rem == 0) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        model_clear();
                        m_done = 1;
                    end else begin
                        front();
                    end
                end
            end
        end else if (s && !was_done) begin
            m_lat[0] = int'(cR);
            m_lat[1] = int'(cG);
            m_lat[2] = int'(cB);
            m_err  = 0;
            m_load = 1;
        end
    endtask

    // One clock: drive pulses, advance the model on the edge, sample 1 time unit later.
    task automatic step(input bit t, input bit s, input bit a, input bit r);
        tick = t; start = s; abort = a; reset = r;
        @(posedge clk);
        model_edge(t, s, a, r);
        #1;
        tick = 1'b0; start = 1'b0; abort = 1'b0; reset = 1'b0;
    endtask

    function automatic bit rtick();
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic test_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        checks++;
        if (vec !== 13'd0) begin
            errors++;
            $display("FAIL reset act=%h exp=%h", vec, 13'd0);
        end
        step(rtick(), 0, 0, 0);
        checks++;
        if (vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle act=%h exp=%h", vec, exp_vec());
        end
    endtask

    task automatic test_basic();
        int n = 0;
        int dones = 0;
        bit fin = 0;
        logic [1:0] last = 2'd0;
        logic [1:0] seq[$];
        logic [1:0] exp_seq[4];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        cR = 5'd2; cG = 5'd3; cB = 5'd1;
        while (!fin && n < 600) begin
            step((n == 0) ? 1'b0 : rtick(), n == 0, 0, 0);
            n++;
            checks++;
            if (vec !== exp_vec()) begin
                errors++;
                $display("FAIL basic cyc=%0d act=%h exp=%h", n, vec, exp_vec());
            end
            checks++;
            if ($countones(motores) > 1) begin
                errors++;
                $display("FAIL basic_onehot act=%b exp=at most one bit", motores);
            end
            if (done) dones++;
            if (canal != last) begin
                seq.push_back(canal);
                last = canal;
            end
            if (m_done) fin = 1;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL basic_timeout act=%0d cycles exp=completion", n);
        end
        for (int i = 0; i < 3; i++) begin
            step(rtick(), 0, 0, 0);
            if (done) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL basic_done_count act=%0d exp=1", dones);
        end
        checks++;
        if (seq.size() != 4) begin
            errors++;
            $display("FAIL basic_canal_len act=%0d exp=4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seq[i] !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL basic_canal_seq[%0d] act=%0d exp=%0d", i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_skip_zero();
        int n = 0;
        int on_ticks = 0;
        bit fin = 0;
        bit t;
        bit was_on;
        cR = 5'd0; cG = 5'd4; cB = 5'd0;
        while (!fin && n < 600) begin
            t = (n == 0) ? 1'b0 : rtick();
            was_on = (motores == 3'b010);
            step(t, n == 0, 0, 0);
            n++;
            if (was_on && t) on_ticks++;
            checks++;
            if (vec !== exp_vec()) begin
                errors++;
                $display("FAIL skip cyc=%0d act=%h exp=%h", n, vec, exp_vec());
            end
            if (m_done) fin = 1;
        end
        checks++;
        if (!fin || done !== 1'b1) begin
            errors++;
            $display("FAIL skip_done act=%b exp=1", done);
        end
        checks++;
        if (on_ticks != 4) begin
            errors++;
            $display("FAIL skip_on_ticks act=%0d exp=4", on_ticks);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_all_zero();
        cR = 5'd0; cG = 5'd0; cB = 5'd0;
        step(1, 1, 0, 0);
        checks++;
        if ({busy, done, motores} !== 5'b10000) begin
            errors++;
            $display("FAIL zero_load act=%b exp=%b", {busy, done, motores}, 5'b10000);
        end
        step(rtick(), 0, 0, 0);
        checks++;
        if ({busy, done, motores} !== 5'b01000) begin
            errors++;
            $display("FAIL zero_done act=%b exp=%b", {busy, done, motores}, 5'b01000);
        end
        step(rtick(), 0, 0, 0);
        checks++;
        if (vec !== exp_vec() || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_after act=%h exp=%h", vec, exp_vec());
        end
    endtask

    task automatic test_error();
        int n = 0;
        bit fin = 0;
        cR = 5'd5; cG = 5'd12; cB = 5'd1;
        step(0, 1, 0, 0);
        step(rtick(), 0, 0, 0);
        checks++;
        if ({error, busy, motores} !== 5'b10000) begin
            errors++;
            $display("FAIL err_set act=%b exp=%b", {error, busy, motores}, 5'b10000);
        end
        for (int i = 0; i < 12; i++) begin
            step(rtick(), 0, 0, 0);
            checks++;
            if (vec !== exp_vec() || motores !== 3'b000 || done !== 1'b0) begin
                errors++;
                $display("FAIL err_hold act=%h exp=%h", vec, exp_vec());
            end
        end
        cR = 5'd1; cG = 5'd1; cB = 5'd1;
        step(0, 1, 0, 0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL err_clear act=%b exp=0", error);
        end
        while (!fin && n < 600) begin
            step(rtick(), 0, 0, 0);
            n++;
            checks++;
            if (vec !== exp_vec()) begin
                errors++;
                $display("FAIL err_rerun cyc=%0d act=%h exp=%h", n, vec, exp_vec());
            end
            if (m_done) fin = 1;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL err_rerun_timeout act=%0d cycles exp=completion", n);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_abort();
        int n = 0;
        int g_ticks = 0;
        bit aborted = 0;
        bit fin = 0;
        bit t;
        bit a;
        cR = 5'd3; cG = 5'd3; cB = 5'd3;
        step(0, 1, 0, 0);
        while (!aborted && n < 600) begin
            t = rtick();
            a = 0;
            if (motores == 3'b010) begin
                if (g_ticks == 1) begin
                    t = 1; a = 1;
                end else if (t) g_ticks++;
            end
            step(t, 0, a, 0);
            n++;
            if (a) aborted = 1;
        end
        checks++;
        if (!aborted || {motores, busy, done, canal, restantes} !== 12'd0) begin
            errors++;
            $display("FAIL abort_now act=%h exp=0", {motores, busy, done, canal, restantes});
        end
        for (int i = 0; i < 8; i++) begin
            step(rtick(), 0, 0, 0);
            checks++;
            if (vec !== exp_vec() || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle act=%h exp=%h", vec, exp_vec());
            end
        end
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if ({motores, canal, restantes} !== {3'b100, 2'd1, 5'd3}) begin
            errors++;
            $display("FAIL abort_restart act=%h exp=%h", {motores, canal, restantes},
                     {3'b100, 2'd1, 5'd3});
        end
        n = 0;
        while (!fin && n < 800) begin
            step(rtick(), 0, 0, 0);
            n++;
            checks++;
            if (vec !== exp_vec()) begin
                errors++;
                $display("FAIL abort_rerun cyc=%0d act=%h exp=%h", n, vec, exp_vec());
            end
            if (m_done) fin = 1;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL abort_rerun_timeout act=%0d cycles exp=completion", n);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_ignore_and_reset();
        int n = 0;
        int dones = 0;
        bit fin = 0;
        bit s;
        bit hit = 0;
        cR = 5'($urandom_range(1, 9)); cG = 5'($urandom_range(1, 9)); cB = 5'($urandom_range(1, 9));
        step(0, 1, 0, 0);
        while (!fin && n < 800) begin
            s = 0;
            if (m_run && m_mot != 3'b000 && $urandom_range(0, 2) == 0) begin
                s = 1;
                cG = 5'($urandom_range(0, 9));
            end
            step(rtick(), s, 0, 0);
            n++;
            checks++;
            if (vec !== exp_vec()) begin
                errors++;
                $display("FAIL ignore cyc=%0d act=%h exp=%h", n, vec, exp_vec());
            end
            if (done) dones++;
            if (m_done) fin = 1;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignore_done act=%0d exp=1", dones);
        end
        step(0, 0, 0, 0);
        cR = 5'($urandom_range(1, 9)); cG = 5'($urandom_range(1, 9)); cB = 5'($urandom_range(1, 9));
        step(0, 1, 0, 0);
        n = 0;
        while (!hit && n < 800) begin
            if (m_run && m_mot == 3'b000) begin
                step(1, 0, 0, 1);
                hit = 1;
            end else begin
                step(rtick(), 0, 0, 0);
            end
            n++;
        end
        checks++;
        if (!hit || vec !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_gap act=%h exp=%h", vec, 13'd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                cR = 5'($urandom_range(0, 11));
                cG = 5'($urandom_range(0, 11));
                cB = 5'($urandom_range(0, 6));
            end
            step(rtick(), $urandom_range(0, 14) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 299) == 0);
            checks++;
            if (vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d act=%h exp=%h", i, vec, exp_vec());
            end
            checks++;
            if ($countones(motores) > 1) begin
                errors++;
                $display("FAIL random_onehot act=%b exp=at most one bit", motores);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip_zero();
        test_all_zero();
        test_error();
        test_abort();
        test_ignore_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_motores.md
Name: secuenciador_motores

Overview:
Dispensing scheduler that drives the three pump motors one at a time from the R/G/B cycle counts held in the RGB memory.
- On a start pulse it latches the counts and runs motor R, then G, then B.
- Each motor stays on for its count in timebase ticks, with a fixed idle gap between motors.
- It arbitrates the single motor bus so that at most one motor is ever on, and it exposes progress (channel, remaining ticks) for the display and the LEDs.

Parameters:
GAP_TICKS, 2, ticks of idle gap between consecutive active channels (>=1)
MAX_CICLOS, 9, largest legal count per channel; a larger count is an error
W, 5, width of each count input and of restantes

Ports:
clk  in  1  system clock (50 MHz); every register is clocked on its rising edge
reset  in  1  synchronous, active-high; returns the block to IDLE
tick  in  1  one-clk-wide timebase pulse (400 ms period) in the clk domain
start  in  1  one-clk pulse requesting a dispense cycle
abort  in  1  level; stops dispensing immediately
ciclos_R  in  W  on-time in ticks for motor R
ciclos_G  in  W  on-time in ticks for motor G
ciclos_B  in  W  on-time in ticks for motor B
motores  out  3  active-high motor enables, {R,G,B} = bits {2,1,0}; inversion happens at the top level
busy  out  1  high while in LOAD/RUN/GAP
done  out  1  one-clk pulse when a dispense cycle completes normally
error  out  1  sticky: a count exceeded MAX_CICLOS; cleared by the next accepted start or by reset
canal  out  2  0 = idle, 1 = R, 2 = G, 3 = B (channel currently running or next after the gap)
restantes  out  W  ticks left on the current channel (RUN) or in the gap (GAP); 0 otherwise

Behaviour:
- All outputs are registered. Reset values: motores=0, busy=0, done=0, error=0, canal=0, restantes=0, state=IDLE, latched counts=0.
- States: IDLE, LOAD, RUN, GAP, DONE.
- IDLE:
  - start=1 latches ciclos_R/G/B, clears error and moves to LOAD.
  - start while busy or in DONE is ignored.
- LOAD (one clk):
  - If any latched count > MAX_CICLOS: set error=1, go to IDLE, no done, motores stay 0.
  - Otherwise select the first channel with a nonzero count in R, G, B order, load restantes with that count and go to RUN.
  - If all counts are 0, go straight to DONE.
- RUN:
  - Exactly one motores bit is high, matching canal; it goes high on the clk after LOAD. Start-to-motor latency is 2 clk.
  - Each tick decrements restantes.
  - On the tick that takes restantes from 1 to 0, the motor bit clears on the same edge.
  - If a later channel has a nonzero count: go to GAP, restantes=GAP_TICKS, canal=next channel.
  - Otherwise go to DONE.
  - Zero-count channels are skipped: no RUN and no GAP for them.
- GAP:
  - motores=0.
  - Each tick decrements restantes.
  - On the tick reaching 0, restantes takes the next channel's count and the state returns to RUN.
- DONE (one clk): done=1, motores=0, canal=0, then IDLE.
- The first on-period may be shorter than a full tick period, because tick is free-running relative to start. This is accepted.
- A tick in the same cycle as start or LOAD is ignored.
- abort=1 in any state: on the next edge motores=0, busy=0, canal=0, restantes=0, state=IDLE, no done pulse. error is unchanged.
- abort has priority over tick and start in the same cycle.
- reset has priority over everything. Reset mid-operation behaves like abort and also clears error.
- Invariant: popcount(motores) <= 1 in every cycle.
- Latched counts are not affected by changes on ciclos_* while busy.
- Decrement arithmetic is W-bit unsigned. restantes never wraps below 0: decrementing at 0 is impossible by construction, and an assertion checks this.

Test Plan:
1. R=2, G=3, B=1, GAP_TICKS=2, start.
   - Expect motores=100 for 2 ticks, 000 for 2 ticks, 010 for 3 ticks, 000 for 2 ticks, 001 for 1 tick.
   - Then one done pulse, busy falls the same edge done rises, canal sequence 1,2,3,0.
2. R=0, G=4, B=0, start.
   - Expect no R phase and no gap: motores=010 for 4 ticks, then done. Total of exactly 4 ticks between the motor turning on and done.
3. R=0, G=0, B=0, start.
   - Expect done exactly 2 clk after start, motores always 000, busy high for 1 clk (LOAD).
4. R=5, G=12, B=1, start.
   - Expect error=1 two clk after start, motores never nonzero, no done.
   - Then R=1, G=1, B=1 with start: error clears on the start edge and the normal sequence runs.
5. R=3, G=3, B=3, start, then abort during the second G tick coinciding with tick.
   - Expect motores=000 on the next edge, busy=0, no done, restantes=0.
   - A new start afterwards runs a full R phase from 3.
6. Start pulsed again mid-RUN, and ciclos_G changed mid-RUN.
   - Expect both ignored: the sequence completes with the original counts.
   - Run reset mid-GAP in the same bench: all outputs at reset values on the next clk.
